// File: rtl/serial_parallel_if.sv
// Receive-path bus of the deserializer: the serial line bit in, the framed
// parallel word and its status strobes out.
interface serial_parallel_if #(
  parameter int WIDTH = 10
);
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             word_valid;
  logic             comma_det;
  logic             aligned;

  // The deserializer drives the parallel side; the line/consumer side is the slave.
  modport master (
    input  serial_in,
    output parallel_out,
    output word_valid,
    output comma_det,
    output aligned
  );

  modport slave (
    output serial_in,
    input  parallel_out,
    input  word_valid,
    input  comma_det,
    input  aligned
  );
endinterface

// File: rtl/serial_parallel.sv
// Serial-in parallel-out deserializer: LSB-first word assembly with optional
// K28.5 comma detection that re-frames the word boundary.
module serial_parallel #(
  parameter int         WIDTH    = 10,
  parameter bit         ALIGN_EN = 1'b1,
  parameter logic [9:0] COMMA_P  = 10'h17C,
  parameter logic [9:0] COMMA_N  = 10'h283
) (
  input logic               clk,
  input logic               reinicio,
  serial_parallel_if.master bus
);
  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] parallel_q, parallel_d;
  logic             valid_q, valid_d;
  logic             comma_q, comma_d;
  logic             aligned_q, aligned_d;
  logic             commaHit;
  logic             boundary;
  logic             load;

  // Comma patterns are 10-bit code groups, so matching only exists at WIDTH == 10.
  generate
    if (WIDTH == 10) begin : gAlign
      assign commaHit = ALIGN_EN && ((shift_d == COMMA_P) || (shift_d == COMMA_N));
    end else begin : gNoAlign
      assign commaHit = 1'b0;
    end
  endgenerate

  always_comb begin
    shift_d    = {bus.serial_in, shift_q[WIDTH-1:1]};
    boundary   = (cnt_q == LAST);
    load       = boundary || commaHit;
    cnt_d      = load ? '0 : cnt_q + CNT_W'(1);
    parallel_d = load ? shift_d : parallel_q;
    valid_d    = load;
    comma_d    = commaHit;
    aligned_d  = aligned_q || commaHit;
  end

  always_ff @(posedge clk) begin
    if (reinicio) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      parallel_q <= '0;
      valid_q    <= 1'b0;
      comma_q    <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      parallel_q <= parallel_d;
      valid_q    <= valid_d;
      comma_q    <= comma_d;
      aligned_q  <= aligned_d;
    end
  end

  assign bus.parallel_out = parallel_q;
  assign bus.word_valid   = valid_q;
  assign bus.comma_det    = comma_q;
  assign bus.aligned      = aligned_q;
endmodule

// File: tb/tb_serial_parallel.sv
// Directed bench for serial_parallel: an aligning and a free-running instance
// share one line and are checked one edge at a time against hand-derived values.
module tb_serial_parallel;
  logic clk;
  logic reinicio;
  int   compared;
  int   mismatched;

  serial_parallel_if #(.WIDTH(10)) busA ();
  serial_parallel_if #(.WIDTH(10)) busN ();

  serial_parallel #(.WIDTH(10), .ALIGN_EN(1'b1)) dutAlign (
    .clk      (clk),
    .reinicio (reinicio),
    .bus      (busA)
  );

  serial_parallel #(.WIDTH(10), .ALIGN_EN(1'b0)) dutFree (
    .clk      (clk),
    .reinicio (reinicio),
    .bus      (busN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sin;
    logic [9:0] par;
    logic       valid;
    logic       comma;
    logic       algn;
  } vec_t;

  vec_t plainTab [13];

  function automatic logic [63:0] bitsOf(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == "1");
    return r;
  endfunction

  task automatic applyStimulus(input logic s, input logic r);
    busA.serial_in = s;
    busN.serial_in = s;
    reinicio       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic cmpField(input string tag, input int edgeNo, input string field,
                          input logic [9:0] act, input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s edge %0d %s: got %h, expected %h", tag, edgeNo, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int edgeNo, input bit useFree,
                             input logic [9:0] ePar, input logic eValid,
                             input logic eComma, input logic eAligned);
    logic [9:0] aPar;
    logic       aValid, aComma, aAligned;
    if (useFree) begin
      aPar = busN.parallel_out; aValid = busN.word_valid;
      aComma = busN.comma_det;  aAligned = busN.aligned;
    end else begin
      aPar = busA.parallel_out; aValid = busA.word_valid;
      aComma = busA.comma_det;  aAligned = busA.aligned;
    end
    cmpField(tag, edgeNo, "parallel_out", aPar, ePar);
    cmpField(tag, edgeNo, "word_valid", {9'd0, aValid}, {9'd0, eValid});
    cmpField(tag, edgeNo, "comma_det", {9'd0, aComma}, {9'd0, eComma});
    cmpField(tag, edgeNo, "aligned", {9'd0, aAligned}, {9'd0, eAligned});
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
  endtask

  // Loads land at edges v0/v1/v2 (999 = none) with words w0/w1/w2; commaEdge 0 = no comma.
  task automatic runStream(input string tag, input logic [63:0] bits, input int n,
                           input int v0, input int v1, input int v2,
                           input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2,
                           input int commaEdge, input bit useFree);
    logic [9:0] ePar;
    for (int e = 1; e <= n; e++) begin
      applyStimulus(bits[e-1], 1'b0);
      if (e >= v2)      ePar = w2;
      else if (e >= v1) ePar = w1;
      else if (e >= v0) ePar = w0;
      else              ePar = 10'h000;
      checkOutput(tag, e, useFree, ePar, (e == v0) || (e == v1) || (e == v2),
                  e == commaEdge, (commaEdge > 0) && (e >= commaEdge));
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    reinicio       = 1'b1;
    busA.serial_in = 1'b1;
    busN.serial_in = 1'b1;

    //                 rst   sin   par      valid comma algn
    plainTab[0]  = '{1'b1, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[1]  = '{1'b1, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[2]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[4]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[5]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[6]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[7]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[9]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[10] = '{1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    plainTab[11] = '{1'b0, 1'b1, 10'h3B5, 1'b1, 1'b0, 1'b0};
    plainTab[12] = '{1'b0, 1'b0, 10'h3B5, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(plainTab[i].sin, plainTab[i].rst);
      checkOutput($sformatf("plain[%0d]", i), i, 1'b0, plainTab[i].par,
                  plainTab[i].valid, plainTab[i].comma, plainTab[i].algn);
    end

    doReset();
    runStream("zeros", bitsOf(""), 30, 10, 20, 30, 10'h000, 10'h000, 10'h000, 0, 1'b0);

    doReset();
    runStream("commaRDm", bitsOf("1110011111010"), 25, 10, 13, 23,
              10'h3E7, 10'h17C, 10'h000, 13, 1'b0);

    doReset();
    runStream("commaRDp", bitsOf("1100000101"), 12, 10, 999, 999,
              10'h283, 10'h000, 10'h000, 10, 1'b0);

    // Partial word after the RD+ comma, then a one-cycle reset mid-word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("midWord", 17, 1'b0, 10'h283, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midRst", 0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    runStream("postRst", bitsOf("1111111111"), 12, 10, 999, 999,
              10'h3FF, 10'h000, 10'h000, 0, 1'b0);

    doReset();
    runStream("offsetAlign", bitsOf("0001100000101"), 30, 10, 13, 23,
              10'h018, 10'h283, 10'h000, 13, 1'b0);

    doReset();
    runStream("offsetFree", bitsOf("0001100000101"), 30, 10, 20, 30,
              10'h018, 10'h005, 10'h000, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_parallel.md
# serial_parallel

Serial-in, parallel-out (SIPO) deserializer for the receive path. It accepts one line bit per clock and assembles WIDTH-bit words, by default 10-bit 8b/10b code groups. Each completed word is presented on a registered parallel bus with a one-cycle valid strobe. Optional K28.5 comma detection realigns the word boundary so downstream 10b/8b decoding sees correctly framed symbols.

## Interface
Parameters:
- WIDTH, 10: word length in bits (≥2).
- ALIGN_EN, 1: 1 = comma detection realigns the word boundary; 0 = free-running framing.
- COMMA_P, 10'h17C: K28.5 RD− pattern, as it appears in the shift register.
- COMMA_N, 10'h283: K28.5 RD+ pattern, as it appears in the shift register.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reinicio, input, 1: reset, synchronous, active-high.
- serial_in, input, 1: line bit, sampled every rising edge.
- parallel_out, output, WIDTH: last completed word, registered.
- word_valid, output, 1: one-cycle pulse when parallel_out is loaded.
- comma_det, output, 1: one-cycle pulse when a load was caused by a comma match.
- aligned, output, 1: sticky flag, set at the first comma match.

## Operation
- Bit order is LSB-first: the first received bit of a word lands in parallel_out[0], the last in parallel_out[WIDTH-1].
- Shift register shreg (WIDTH bits) updates every clock: shreg_next = {serial_in, shreg[WIDTH-1:1]}.
- Bit counter cnt, ceil(log2(WIDTH)) bits, counts 0..WIDTH-1 and wraps to 0.
- Word boundary when cnt == WIDTH-1 on this edge:
  - parallel_out <= shreg_next
  - word_valid <= 1
  - cnt <= 0
- Comma match when ALIGN_EN=1 and shreg_next equals COMMA_P or COMMA_N. This applies at any cnt value:
  - parallel_out <= shreg_next
  - word_valid <= 1
  - comma_det <= 1
  - aligned <= 1
  - cnt <= 0
- Comma and normal boundary on the same edge: one load and one word_valid pulse; comma_det = 1.
- A comma mid-word discards the partial framing. No word is emitted for the discarded bits beyond the comma load itself.
- Otherwise: cnt increments, parallel_out holds, word_valid = 0, comma_det = 0.
- Comma comparison applies only when WIDTH = 10. For other WIDTH values, alignment logic is disabled regardless of ALIGN_EN.
- aligned stays set until reset. Later commas re-frame again but do not clear it.

## Timing
- Reset (reinicio high at an edge) has priority over every other action. It clears:
  - shreg = 0, cnt = 0
  - parallel_out = 0
  - word_valid = 0, comma_det = 0, aligned = 0
- Reset mid-word discards the partial word.
- First bit counted is the one sampled at the first edge with reinicio low.
- Unaligned latency: parallel_out updates on the WIDTH-th edge after reset release, then every WIDTH edges.
- After a comma at edge N, the next normal boundary is edge N+WIDTH.
- word_valid and comma_det are high for exactly the one cycle following the loading edge.
- parallel_out is stable between loads.
- No combinational path from serial_in to any output.

## Test plan
- Reset: hold reinicio for 2 cycles with serial_in=1 → all outputs 0, no word_valid.
- Plain word (ALIGN_EN=1): after reset, send bits 1,0,1,0,1,1,0,1,1,1 (first bit first) → at the 10th edge parallel_out=10'h3B5, word_valid pulses once, comma_det=0, aligned=0.
- Continuous stream: 30 zero bits after reset → word_valid at edges 10, 20 and 30, parallel_out=10'h000 each time.
- Comma realignment: after reset, send 1,1,1, then K28.5 RD− bits 0,0,1,1,1,1,1,0,1,0.
  - Edge 10: word 10'h3E7 (bits 1,1,1,0,0,1,1,1,1,1).
  - Edge 13: parallel_out=10'h17C, word_valid=1, comma_det=1, aligned=1.
  - Next word_valid at edge 23.
- RD+ comma and ALIGN_EN=0:
  - With ALIGN_EN=1, bits 1,1,0,0,0,0,0,1,0,1 give 10'h283 with comma_det.
  - With ALIGN_EN=0, the same stream offset by 3 bits gives no comma_det, aligned stays 0, and framing stays on a 10-edge cadence.
- Reset mid-word: after 5 bits, assert reinicio for 1 cycle → outputs cleared. The next word_valid comes 10 edges after release, with only post-reset bits in parallel_out.
